// File: rtl/zacore_common.sv
// Shared types and constants for the zacore RV32I pipeline.
//   fetch_decode_if_t   : fetch -> decode bundle (valid, pc, inst)
//   decode_execute_if_t : decode -> execute bundle (operands, immediate, control)
//   opcode_t, alu_op_t, mem_size_t, imm_fmt_t : decode enumerations
package zacore_common;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } datapath_info_t;

  typedef struct packed {
    datapath_info_t  datapath_info;
    logic [31:0]     inst;
  } fetch_decode_if_t;

  typedef enum logic [6:0] {
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_JAL      = 7'b1101111,
    OPC_JALR     = 7'b1100111,
    OPC_BRANCH   = 7'b1100011,
    OPC_LOAD     = 7'b0000011,
    OPC_STORE    = 7'b0100011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP       = 7'b0110011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_addr;
    logic [4:0]      rs1_addr;   // kept so execute can forward
    logic [4:0]      rs2_addr;
    logic [2:0]      funct3;     // branch condition / CSR op for execute
    logic            rd_we;
    alu_op_t         alu_op;
    logic            alu_src_imm;
    logic            mem_read;
    logic            mem_write;
    mem_size_t       mem_size;
    logic            mem_unsigned;
    logic            branch;
    logic            jump;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            illegal;
  } decode_execute_if_t;

  // alt = funct7[5], already qualified by the caller (OP, or OP_IMM shift-right).
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic mem_size_t mem_size_decode(input logic [1:0] size_bits);
    case (size_bits)
      2'b00:   return MEM_BYTE;
      2'b01:   return MEM_HALF;
      default: return MEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/zacore_imm_gen.sv
// Immediate generator: extracts and sign-extends the immediate of an RV32I
// instruction for the given format.
//   inst : in  32  raw instruction word
//   fmt  : in  imm_fmt_t  immediate layout (R gives 0)
//   imm  : out 32  sign-extended immediate (combinational)
module zacore_imm_gen
  import zacore_common::*;
(
  input  logic [31:0] inst,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  // Opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^inst[6:0];

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm = {inst[31:12], 12'b0};
      IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/zacore_decode.sv
// zacore decode stage: decodes one fetched instruction per cycle into control
// fields and an immediate, registers it toward execute (1-cycle latency) and
// inserts a single bubble on a load-use hazard.
//   i_clk / i_rst            : clock, synchronous active-high reset
//   i_fetch_decode_if        : valid, pc, inst from fetch
//   o_rs1_addr / o_rs2_addr  : register file read addresses (combinational)
//   i_rs1_data / i_rs2_data  : register file read data, same cycle
//   o_decode_execute_if      : registered decoded instruction
//   o_load_use_stall         : stall request to fetch (combinational)
//   i_stall                  : downstream stall, hold output register
//   i_invalidate             : flush, clear output valid
module zacore_decode
  import zacore_common::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  fetch_decode_if_t   i_fetch_decode_if,
  output logic [4:0]         o_rs1_addr,
  output logic [4:0]         o_rs2_addr,
  input  logic [31:0]        i_rs1_data,
  input  logic [31:0]        i_rs2_data,
  output decode_execute_if_t o_decode_execute_if,
  output logic               o_load_use_stall,
  input  logic               i_stall,
  input  logic               i_invalidate
);

  logic [31:0]        inst;
  logic [2:0]         funct3;
  imm_fmt_t           fmt;
  logic [31:0]        imm;
  decode_execute_if_t ctrl;
  decode_execute_if_t dec;
  decode_execute_if_t out_reg;
  logic               hazard;

  assign inst       = i_fetch_decode_if.inst;
  assign funct3     = inst[14:12];
  assign o_rs1_addr = inst[19:15];
  assign o_rs2_addr = inst[24:20];

  zacore_imm_gen u_imm_gen (
    .inst (inst),
    .fmt  (fmt),
    .imm  (imm)
  );

  // Control decode; the immediate is merged in a separate block so the
  // format select does not loop back through the same process.
  always_comb begin
    ctrl          = '0;
    fmt           = IMM_R;
    ctrl.valid    = i_fetch_decode_if.datapath_info.valid;
    ctrl.pc       = i_fetch_decode_if.datapath_info.pc;
    ctrl.rs1_data = i_rs1_data;
    ctrl.rs2_data = i_rs2_data;
    ctrl.rd_addr  = inst[11:7];
    ctrl.rs1_addr = inst[19:15];
    ctrl.rs2_addr = inst[24:20];
    ctrl.funct3   = funct3;
    ctrl.alu_op   = ALU_ADD;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        fmt              = IMM_U;
        ctrl.alu_src_imm = 1'b1;
      end
      OPC_JAL: begin
        fmt              = IMM_J;
        ctrl.alu_src_imm = 1'b1;
        ctrl.jump        = 1'b1;
      end
      OPC_JALR: begin
        fmt              = IMM_I;
        ctrl.alu_src_imm = 1'b1;
        ctrl.jump        = 1'b1;
        ctrl.uses_rs1    = 1'b1;
      end
      OPC_BRANCH: begin
        fmt           = IMM_B;
        ctrl.branch   = 1'b1;
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        fmt               = IMM_I;
        ctrl.alu_src_imm  = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.uses_rs1     = 1'b1;
        ctrl.mem_size     = mem_size_decode(funct3[1:0]);
        ctrl.mem_unsigned = funct3[2];
      end
      OPC_STORE: begin
        fmt              = IMM_S;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
        ctrl.uses_rs1    = 1'b1;
        ctrl.uses_rs2    = 1'b1;
        ctrl.mem_size    = mem_size_decode(funct3[1:0]);
      end
      OPC_OP_IMM: begin
        fmt              = IMM_I;
        ctrl.alu_src_imm = 1'b1;
        ctrl.uses_rs1    = 1'b1;
        // funct7[5] only selects SRAI; elsewhere it is immediate data.
        ctrl.alu_op      = alu_decode(funct3, (funct3 == 3'b101) & inst[30]);
      end
      OPC_OP: begin
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
        ctrl.alu_op   = alu_decode(funct3, inst[30]);
      end
      OPC_MISC_MEM: begin
        fmt = IMM_I;
      end
      OPC_SYSTEM: begin
        fmt           = IMM_I;
        // Register-source CSR ops (CSRRW/S/C) read rs1; the immediate forms don't.
        ctrl.uses_rs1 = (funct3 != 3'b000) & ~funct3[2];
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
    ctrl.rd_we = (inst[11:7] != 5'd0) &
                 (inst[6:0] != OPC_STORE) & (inst[6:0] != OPC_BRANCH);
  end

  always_comb begin
    dec     = ctrl;
    dec.imm = imm;
  end

  // Load in execute whose destination is read by the incoming instruction.
  assign hazard = out_reg.valid & out_reg.mem_read & (out_reg.rd_addr != 5'd0) &
                  i_fetch_decode_if.datapath_info.valid &
                  ((dec.uses_rs1 & (inst[19:15] == out_reg.rd_addr)) |
                   (dec.uses_rs2 & (inst[24:20] == out_reg.rd_addr)));

  assign o_load_use_stall = hazard & ~i_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_reg <= '0;
    end else if (i_invalidate) begin
      out_reg.valid <= 1'b0;
    end else if (i_stall) begin
      out_reg <= out_reg;
    end else if (hazard) begin
      out_reg.valid <= 1'b0;
    end else begin
      out_reg <= dec;
    end
  end

  assign o_decode_execute_if = out_reg;

endmodule

// File: doc/zacore_decode.md
# zacore_decode

Second pipeline stage of the zacore RV32I core, sitting between `zacore_fetch` and execute. Each cycle it consumes one fetched instruction (`fetch_decode_if_t`) and decodes it into control fields and a sign-extended immediate. It drives the register-file read addresses and registers the result into `decode_execute_if_t` with one cycle of latency. It also detects load-use hazards and inserts a single bubble while requesting an upstream stall.

## Interface
Parameters:
- none. All widths come from `zacore_common`.

Ports:
- `i_clk`  in  1  clock; all state updates on posedge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_fetch_decode_if`  in  `fetch_decode_if_t`  `datapath_info.valid`, `datapath_info.pc`, `inst` from fetch.
- `o_rs1_addr`  out  5  `inst[19:15]`, combinational, to register file.
- `o_rs2_addr`  out  5  `inst[24:20]`, combinational, to register file.
- `i_rs1_data`  in  32  register file read data for `o_rs1_addr`, same cycle.
- `i_rs2_data`  in  32  register file read data for `o_rs2_addr`, same cycle.
- `o_decode_execute_if`  out  `decode_execute_if_t`  registered decoded instruction to execute.
- `o_load_use_stall`  out  1  combinational stall request; OR-ed into fetch `i_stall`.
- `i_stall`  in  1  downstream stall; hold the output register.
- `i_invalidate`  in  1  flush; kill the output register contents.

## Operation
- Opcode classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM.
  - Any other opcode, or `inst[1:0] != 2'b11`, sets `illegal=1`.
  - An illegal instruction still carries its valid bit; execute raises the trap.
- Immediate formats I, S, B, U, J, each sign-extended to 32 bits from `inst[31]`. R-type immediate is 0.
- Control fields:
  - `alu_op` from funct3 and funct7[5]. funct7[5] is honoured only for OP, and for OP_IMM SRAI.
  - `alu_src_imm`.
  - `rd_addr`; `rd_we` is 0 when rd==x0 or the class is STORE/BRANCH.
  - `mem_read`, `mem_write`, `mem_size`/`mem_unsigned` from funct3.
  - `branch`, `jump`, `uses_rs1`, `uses_rs2`.
- Payload: `pc`, `rs1_data`, `rs2_data`, `imm`, control fields, `valid`.
- Load-use hazard, H = all of:
  - `o_decode_execute_if.valid`;
  - `o_decode_execute_if.mem_read`;
  - its `rd_addr != 0`;
  - `i_fetch_decode_if.valid`;
  - (`uses_rs1` & rs1==rd) or (`uses_rs2` & rs2==rd).
- `o_load_use_stall = H & ~i_stall`.
- Register update priority, highest first:
  1. `i_rst`: all output fields 0, `valid=0`.
  2. `i_invalidate`: `valid<=0`; payload don't-care.
  3. `i_stall`: hold all fields.
  4. H: `valid<=0` (bubble); the incoming instruction is held upstream because fetch sees the stall.
  5. Otherwise: load decoded payload, `valid <= i_fetch_decode_if.valid`.

## Timing
- Latency: 1 cycle from a fetch output to `o_decode_execute_if`.
- Register addresses and `o_load_use_stall` are combinational from the current inputs.
- Load-use: exactly one bubble cycle.
  - Once the bubble is latched, H deasserts on the next cycle.
  - The held dependent instruction then advances and forwards the load result from the execute stage.
- `i_invalidate` together with `i_stall`: invalidate wins, so `valid=0`.
- `i_invalidate` together with H: `valid=0`, and `o_load_use_stall` is still asserted that cycle.
- Reset mid-stall: after one reset cycle, `valid=0` and `o_load_use_stall=0` (the register is empty, so H=0).
- Reset values of all outputs:
  - `o_decode_execute_if`: all zeros.
  - `o_rs1_addr`/`o_rs2_addr`: follow the input `inst` (combinational).
  - `o_load_use_stall`: 0.

## Structure
- Shared types and constants in `zacore_common`:
  - `decode_execute_if_t`;
  - opcode enum `opcode_t`;
  - `alu_op_t`;
  - `mem_size_t`;
  - `imm_fmt_t`.
- Sub-module `zacore_imm_gen`: combinational, (`inst`, `imm_fmt_t`) → 32-bit immediate.
- Control decode and hazard logic stay in `zacore_decode`.

## Test plan
- ADDI x1,x2,-1 (`0xFFF10093`), valid → next cycle:
  - `imm=0xFFFFFFFF`, `rd_addr=1`, `rd_we=1`;
  - `alu_op=ADD`, `alu_src_imm=1`;
  - `o_rs1_addr=2` combinationally.
- BEQ x0,x0,-4 (`0xFE000EE3`) → `imm=0xFFFFFFFC`, `branch=1`, `rd_we=0`.
- LW x5,0(x1) (`0x0000A283`) then ADD x6,x5,x7 (`0x00728333`):
  - `o_load_use_stall=1` for exactly one cycle, one bubble (`valid=0`);
  - then ADD with `rs1_data` sampled on its advancing cycle.
- ADDI x0,x0,0 (`0x00000013`) → `rd_we=0`, `valid=1`.
- `inst=0x0000007F` → `illegal=1`, `valid=1`.
- Ordering: assert `i_stall` for 3 cycles with a valid instruction latched (output held constant), then `i_invalidate` together with `i_stall` → `valid=0` next cycle.
